// File: rtl/fifo_stream_out.sv
// Drains the synchronous FIFO onto a valid/ready stream through a 2-slot skid buffer,
// tagging every PKT_LEN-th beat with m_last and counting completed packets.
module fifo_stream_out #(
  parameter int DW      = 32,
  parameter int PKT_LEN = 16,
  parameter int PCW     = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fifo_nempty,
  input  logic [DW-1:0]  fifo_rdata,
  output logic           fifo_read,
  output logic           fifo_clr,
  input  logic           flush,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DW-1:0]  m_data,
  output logic           m_last,
  output logic [PCW-1:0] pkt_cnt,
  output logic           busy
);

  typedef enum logic {RUN = 1'b0, CLR = 1'b1} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  state_t          state;
  logic [1:0]      count;
  logic [DW-1:0]   data1;
  logic            last1;
  logic [15:0]     beat;
  logic            push;
  logic            pop;
  logic            push_last;

  // Slot0 is held directly in m_data/m_last so the outputs are pure registers.
  always_comb begin
    push      = fifo_nempty & (count != 2'd2) & (state == RUN) & ~flush & ~rst;
    fifo_read = push;
    m_valid   = (count != 2'd0);
    pop       = m_valid & m_ready;
    push_last = (beat == LAST_BEAT);
    busy      = m_valid | (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      count    <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
      data1    <= '0;
      last1    <= 1'b0;
      beat     <= '0;
      fifo_clr <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      fifo_clr <= 1'b0;
      case (state)
        RUN: begin
          if (flush) begin
            state    <= CLR;
            count    <= '0;
            beat     <= '0;
            fifo_clr <= 1'b1;
          end else begin
            if (pop && m_last)
              pkt_cnt <= pkt_cnt + 1'b1;
            if (push)
              beat <= push_last ? '0 : beat + 16'd1;
            // On simultaneous push/pop the new word lands in the slot vacated by the shift.
            case ({push, pop})
              2'b01: begin
                m_data <= data1;
                m_last <= last1;
                count  <= count - 2'd1;
              end
              2'b10: begin
                if (count == 2'd0) begin
                  m_data <= fifo_rdata;
                  m_last <= push_last;
                end else begin
                  data1 <= fifo_rdata;
                  last1 <= push_last;
                end
                count <= count + 2'd1;
              end
              2'b11: begin
                if (count == 2'd1) begin
                  m_data <= fifo_rdata;
                  m_last <= push_last;
                end else begin
                  m_data <= data1;
                  m_last <= last1;
                  data1  <= fifo_rdata;
                  last1  <= push_last;
                end
              end
              default: ;
            endcase
          end
        end
        CLR: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: a queue-based FIFO drives two instances (PKT_LEN 16 and 1)
// sharing all inputs; a packet-level model is compared every cycle, plus literal checks.
module tb_fifo_stream_out;
  localparam int DW = 32;
  localparam int LA = 16;
  localparam int LB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fifo_nempty, flush, m_ready;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_read, fifo_clr, m_valid, m_last, busy;
  logic [DW-1:0] m_data;
  logic [15:0]   pkt_cnt;
  logic          fifo_read_b, fifo_clr_b, m_valid_b, m_last_b, busy_b;
  logic [DW-1:0] m_data_b;
  logic [15:0]   pkt_cnt_b;

  fifo_stream_out #(.DW(DW), .PKT_LEN(LA), .PCW(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_nempty(fifo_nempty), .fifo_rdata(fifo_rdata),
    .fifo_read(fifo_read), .fifo_clr(fifo_clr), .flush(flush), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .pkt_cnt(pkt_cnt), .busy(busy));

  fifo_stream_out #(.DW(DW), .PKT_LEN(LB), .PCW(16)) u_dut_b (
    .clk(clk), .rst(rst), .fifo_nempty(fifo_nempty), .fifo_rdata(fifo_rdata),
    .fifo_read(fifo_read_b), .fifo_clr(fifo_clr_b), .flush(flush), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b), .pkt_cnt(pkt_cnt_b), .busy(busy_b));

  typedef struct { logic [31:0] data; logic la; logic lb; } ent_t;
  typedef struct { logic [31:0] data; logic last; int cyc; } pop_t;

  ent_t        q[$];
  pop_t        log_q[$];
  logic [31:0] fifo_q[$];
  int          nb, n_vec, n_err, cycle, rd_pulses;
  bit          armed, in_clr, exp_clr, just_reset, snap_read, snap_clr;
  logic [15:0] exp_pkt, exp_pkt_b;

  function automatic void cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycle);
    end
  endfunction

  function automatic void fifo_sync();
    fifo_nempty = (fifo_q.size() != 0);
    fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  function automatic void push_words(int base, int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(32'(base + i));
    fifo_sync();
  endfunction

  function automatic bit exp_read();
    return fifo_nempty && (q.size() < 2) && !in_clr && !flush && !rst;
  endfunction

  function automatic void compare();
    bit er = exp_read();
    bit ev = (q.size() != 0);
    cmp("fifo_read", fifo_read, er);
    cmp("fifo_read_b", fifo_read_b, er);
    cmp("m_valid", m_valid, ev);
    cmp("m_valid_b", m_valid_b, ev);
    if (ev) begin
      cmp("m_data", m_data, q[0].data);
      cmp("m_last", m_last, q[0].la);
      cmp("m_data_b", m_data_b, q[0].data);
      cmp("m_last_b", m_last_b, q[0].lb);
    end else if (just_reset) begin
      cmp("rst_m_data", m_data, 0);
      cmp("rst_m_last", m_last, 0);
    end
    cmp("fifo_clr", fifo_clr, exp_clr);
    cmp("fifo_clr_b", fifo_clr_b, exp_clr);
    cmp("pkt_cnt", pkt_cnt, exp_pkt);
    cmp("pkt_cnt_b", pkt_cnt_b, exp_pkt_b);
    cmp("busy", busy, ev || in_clr);
    cmp("busy_b", busy_b, ev || in_clr);
  endfunction

  // Advance the model by the effect of the coming rising edge.
  function automatic void step();
    int   sz = q.size();
    bit   rd = exp_read();
    ent_t e;
    snap_read  = fifo_read;
    snap_clr   = fifo_clr;
    if (fifo_read) rd_pulses++;
    just_reset = 1'b0;
    if (rst) begin
      q.delete();
      nb = 0; in_clr = 0; exp_clr = 0; exp_pkt = '0; exp_pkt_b = '0;
      just_reset = 1'b1; armed = 1'b1;
    end else if (in_clr) begin
      in_clr = 0; exp_clr = 0;
    end else if (flush) begin
      q.delete();
      nb = 0; in_clr = 1; exp_clr = 1;
    end else begin
      if (sz != 0 && m_ready) begin
        if (q[0].la) exp_pkt++;
        if (q[0].lb) exp_pkt_b++;
        log_q.push_back('{data: m_data, last: m_last, cyc: cycle});
        void'(q.pop_front());
      end
      if (rd) begin
        e.data = fifo_rdata;
        e.la   = (nb % LA) == LA - 1;
        e.lb   = (nb % LB) == LB - 1;
        q.push_back(e);
        nb++;
      end
    end
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (armed) compare();
    step();
    @(posedge clk);
    #1;
    if (snap_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (snap_clr) fifo_q.delete();
    fifo_sync();
    cycle++;
  endtask

  task automatic drain(int max_cyc, bit rnd);
    int n = 0;
    while ((fifo_q.size() != 0 || q.size() != 0) && n < max_cyc) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    cmp("drain_in_time", n < max_cyc, 1);
  endtask

  function automatic int seq_errs(int base, int offs, int len);
    int errs = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].data != 32'(base + i) || log_q[i].last != (((offs + i) % len) == len - 1))
        errs++;
    return errs;
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cycle = 0; rd_pulses = 0; nb = 0;
    armed = 0; in_clr = 0; exp_clr = 0; just_reset = 0; snap_read = 0; snap_clr = 0;
    exp_pkt = '0; exp_pkt_b = '0;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_sync();
    cyc(); cyc();
    cmp("rst_valid", m_valid, 0);
    cmp("rst_data", m_data, 0);
    cmp("rst_pkt", pkt_cnt, 0);
    cmp("rst_busy", busy, 0);
    rst = 1'b0;

    // streaming at full rate
    m_ready = 1'b1;
    push_words(0, 40);
    drain(100, 0);
    cmp("t1_count", log_q.size(), 40);
    cmp("t1_seq_errs", seq_errs(0, 0, 16), 0);
    if (log_q.size() == 40) cmp("t1_rate", log_q[39].cyc - log_q[0].cyc, 39);
    cmp("t1_pkt", pkt_cnt, 2);
    cmp("t1_pkt_b", pkt_cnt_b, 40);
    cmp("t1_busy", busy, 0);

    // backpressure
    log_q.delete();
    m_ready = 1'b0;
    push_words(100, 5);
    rd_pulses = 0;
    repeat (10) cyc();
    cmp("t2_reads", rd_pulses, 2);
    cmp("t2_read_now", fifo_read, 0);
    cmp("t2_valid", m_valid, 1);
    cmp("t2_data", m_data, 100);
    m_ready = 1'b1;
    drain(50, 0);
    cmp("t2_count", log_q.size(), 5);
    cmp("t2_seq_errs", seq_errs(100, 40, 16), 0);

    // random ready
    log_q.delete();
    push_words(1000, 1000);
    drain(6000, 1);
    cmp("t3_count", log_q.size(), 1000);
    cmp("t3_seq_errs", seq_errs(1000, 45, 16), 0);
    cmp("t3_pkt", pkt_cnt, 65);
    cmp("t3_pkt_b", pkt_cnt_b, 1045);

    // flush mid-packet with two words buffered
    m_ready = 1'b0;
    log_q.delete();
    push_words(2000, 10);
    repeat (3) cyc();
    cmp("t4_head", m_data, 2000);
    rd_pulses = 0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cmp("t4_valid", m_valid, 0);
    cmp("t4_clr", fifo_clr, 1);
    cmp("t4_pkt", pkt_cnt, 65);
    cyc();
    cmp("t4_clr_done", fifo_clr, 0);
    cmp("t4_reads", rd_pulses, 0);
    cmp("t4_fifo_cleared", fifo_q.size(), 0);
    m_ready = 1'b1;
    push_words(3000, 20);
    drain(100, 0);
    cmp("t4_count", log_q.size(), 20);
    cmp("t4_seq_errs", seq_errs(3000, 0, 16), 0);
    cmp("t4_pkt_after", pkt_cnt, 66);
    cmp("t4_pkt_b", pkt_cnt_b, 1065);

    // flush coinciding with the pop of a last beat
    log_q.delete();
    push_words(4000, 14);
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (m_valid && m_data == 32'd4011) break;
    end
    cmp("t5_head", m_data, 4011);
    cmp("t5_last", m_last, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cmp("t5_valid", m_valid, 0);
    cmp("t5_pkt", pkt_cnt, 66);
    cmp("t5_pkt_b", pkt_cnt_b, 1076);
    if (log_q.size() != 0) cmp("t5_last_popped", log_q[log_q.size()-1].data, 4010);
    cyc(); cyc();

    // reset mid-stream
    log_q.delete();
    push_words(5000, 10);
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    cmp("t6_read_in_rst", fifo_read, 0);
    cmp("t6_read_in_rst_b", fifo_read_b, 0);
    cyc();
    rst = 1'b0;
    cmp("t6_valid", m_valid, 0);
    cmp("t6_data", m_data, 0);
    cmp("t6_last", m_last, 0);
    cmp("t6_pkt", pkt_cnt, 0);
    cmp("t6_busy", busy, 0);
    cmp("t6_pkt_b", pkt_cnt_b, 0);
    log_q.delete();
    push_words(6000, 20);
    drain(100, 0);
    cmp("t6_count", log_q.size(), 26);
    if (log_q.size() != 0) cmp("t6_first", log_q[0].data, 5004);
    cmp("t6_pkt_after", pkt_cnt, 1);
    cmp("t6_pkt_b_after", pkt_cnt_b, 26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
